word_assembler: RTL and testbench
=================================

# word_assembler

Upstream loader for the 32-bit enable register stage. Accepts a byte stream under a valid/ready handshake and packs four bytes, or fewer if `in_last` is seen, into one word. It then presents the word on `out_d` and pulses `out_en` for one cycle, so the downstream register captures it through its `d`/`en` inputs. Each emitted word is counted for debug visibility.

## Interface
- `WIDTH`, 32, output word width; fixed at 32 (4 byte lanes), other values unsupported
- `CNT_W`, 16, width of emitted-word counter
- `clk`  in  1  clock, all state updates on rising edge
- `resetn`  in  1  reset, synchronous, active-low; clock clk
- `in_valid`  in  1  byte on `in_data` is valid
- `in_data`  in  8  input byte
- `in_last`  in  1  qualifies `in_valid`: this byte closes the current word
- `in_ready`  out  1  assembler can accept a byte this cycle
- `out_ready`  in  1  downstream can take a word this cycle
- `out_en`  out  1  one-cycle capture strobe to downstream register `en`
- `out_d`  out  32  assembled word, stable whenever state is FULL
- `out_count`  out  3  valid bytes in `out_d` (1..4), 0 when not FULL
- `word_cnt`  out  CNT_W  words emitted since reset, wraps

## Operation
- Two states:
  - FILL: gathering bytes.
  - FULL: word complete and waiting for the downstream to take it.
- Byte acceptance and lane placement:
  - Accept = `in_valid && in_ready`.
  - In FILL, an accepted byte is written to lane `lane_idx` (0..3) and `lane_idx` increments.
  - With lane `i` = bits `[8i+7:8i]`, byte k of a word goes to lane k (little-endian default).
- FILL → FULL when the accepted byte has `lane_idx==3` or `in_last==1`.
  - `out_count` = bytes in the word.
  - Unfilled lanes read 0.
- FULL behaviour:
  - `out_en = (state==FULL) && out_ready`, combinational.
  - On `out_en`: word clears to 0, `lane_idx` goes to 0, `word_cnt` increments, and state returns to FILL.
- `in_ready = (state==FILL) || out_en`.
  - A byte accepted in the same cycle as `out_en` becomes lane 0 of the next word.
  - If that byte also has `in_last=1`, state stays FULL with a 1-byte word.
- `in_last` with no pending bytes simply yields a 1-byte word. Zero-byte words are never emitted.
- Reset (`resetn==0` at an edge) takes priority over all activity, including mid-word and FULL-awaiting-ready:
  - Partial word discarded, state FILL, `lane_idx`=0.
  - `out_d`=0, `out_count`=0, `word_cnt`=0.
  - `out_en`=0, `in_ready`=1 (first cycle after release).
- `word_cnt` wraps from 2^CNT_W−1 to 0 with no flag.
- `in_data`/`in_last` are ignored when not accepted.

## Timing
- Latency: the 4th byte (or the `in_last` byte) accepted at edge N sets FULL at N.
  - `out_en` is high during cycle N..N+1 if `out_ready` is 1.
  - The downstream register captures at edge N+1.
- Throughput: one byte per cycle sustained, with zero bubbles at word boundaries while `out_ready` stays high.
- Backpressure: while FULL and `out_ready==0`, `in_ready=0` and `out_d`/`out_count` are held unchanged.
- No combinational path from `in_valid` to `in_ready`. `out_ready` → `out_en` → `in_ready` is combinational.

## Configuration
- `WORD_ASSEMBLER_BIG_ENDIAN_EN`:
  - Defined: byte k of a word goes to lane 3−k, so the first byte lands in `[31:24]`, and a partial word is left-justified (unfilled low lanes 0).
  - Undefined: little-endian placement as in Operation.
- Handshake, counts and timing are identical in both builds.

## Test plan
- Full word, little-endian: bytes 0x11,0x22,0x33,0x44 back-to-back, `out_ready`=1 → one `out_en` pulse the cycle after 0x44 accepted, `out_d`=0x44332211, `out_count`=4, `word_cnt`=1.
- Partial word: 0xAA, 0xBB(`in_last`) → `out_d`=0x0000BBAA, `out_count`=2. With `WORD_ASSEMBLER_BIG_ENDIAN_EN` → `out_d`=0xAABB0000.
- Backpressure: complete 0x01..0x04, hold `out_ready`=0 for 5 cycles → `in_ready`=0, `out_en`=0, `out_d`=0x04030201 held; raise `out_ready` → single `out_en`.
- Overlap: 8 consecutive bytes 0x10..0x17, `out_ready`=1 → `in_ready` never drops, two words 0x13121110 and 0x17161514, byte 0x14 accepted in the same cycle as the first `out_en`.
- Reset mid-word: accept 0x55,0x66, assert `resetn`=0 one edge, then send 0x01..0x04 → `out_d`=0x04030201, no trace of 0x55/0x66, `word_cnt`=1.
- Counter wrap (`CNT_W`=4): emit 17 words → `word_cnt` reads 15 after the 15th word, 0 after the 16th, 1 after the 17th.

Source files
------------

// File: rtl/word_assembler.sv
// Byte-stream to 32-bit word packer feeding a d/en register stage, with an emitted-word counter.
// Build option: define WORD_ASSEMBLER_BIG_ENDIAN_EN to place the first byte of a word in [31:24].
//
// state | meaning
// FILL  | gathering bytes into the current word
// FULL  | word complete, held on out_d until the downstream takes it

module word_assembler #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             in_ready,
  input  logic             out_ready,
  output logic             out_en,
  output logic [WIDTH-1:0] out_d,
  output logic [2:0]       out_count,
  output logic [CNT_W-1:0] word_cnt
);

  typedef enum logic {FILL, FULL} state_e;

  state_e           state_q, state_d;
  logic [1:0]       lane_q, lane_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [2:0]       count_q, count_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept;
  logic [WIDTH-1:0] word_base;
  logic [1:0]       lane_cur;
  logic [1:0]       lane_sel;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= FILL;
      lane_q  <= '0;
      word_q  <= '0;
      count_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      count_q <= count_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    out_en    = (state_q == FULL) && out_ready;
    in_ready  = (state_q == FILL) || out_en;
    accept    = in_valid && in_ready;

    state_d   = state_q;
    lane_d    = lane_q;
    word_d    = word_q;
    count_d   = count_q;
    cnt_d     = cnt_q;
    word_base = word_q;
    lane_cur  = lane_q;

    // A byte arriving alongside the handoff starts a fresh word from lane 0.
    if (out_en) begin
      state_d   = FILL;
      lane_d    = '0;
      word_d    = '0;
      count_d   = '0;
      cnt_d     = cnt_q + 1'b1;
      word_base = '0;
      lane_cur  = '0;
    end

`ifdef WORD_ASSEMBLER_BIG_ENDIAN_EN
    lane_sel = ~lane_cur;
`else
    lane_sel = lane_cur;
`endif

    if (accept) begin
      word_d = word_base | (WIDTH'(in_data) << {lane_sel, 3'b000});
      if (lane_cur == 2'd3 || in_last) begin
        state_d = FULL;
        count_d = {1'b0, lane_cur} + 3'd1;
        lane_d  = '0;
      end else begin
        lane_d  = lane_cur + 2'd1;
      end
    end
  end

  assign out_d     = word_q;
  assign out_count = count_q;
  assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_word_assembler.sv
// Randomized and directed bench for word_assembler: a byte-list reference model queues expected
// words, and an independent monitor pops and compares on every out_en.

module tb_word_assembler;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             resetn;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_last;
  logic             in_ready;
  logic             out_ready;
  logic             out_en;
  logic [31:0]      out_d;
  logic [2:0]       out_count;
  logic [CNT_W-1:0] word_cnt;

  always #5 clk = ~clk;

  word_assembler #(.WIDTH(32), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .out_en    (out_en),
    .out_d     (out_d),
    .out_count (out_count),
    .word_cnt  (word_cnt)
  );

  typedef struct {
    logic [31:0] w;
    logic [31:0] n;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] cur[$];
  int         n_pass  = 0;
  int         n_total = 0;
  int         emitted = 0;
  int         mode    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Reference: a word is the list of accepted bytes, byte k weighted by 256^position.
  task automatic model_accept(input logic [7:0] d, input logic last);
    exp_t e;
    int   pos;
    cur.push_back(d);
    if (cur.size() == 4 || last) begin
      e.w = 32'd0;
      for (int k = 0; k < cur.size(); k++) begin
`ifdef WORD_ASSEMBLER_BIG_ENDIAN_EN
        pos = 3 - k;
`else
        pos = k;
`endif
        e.w = e.w + (32'(cur[k]) << (8 * pos));
      end
      e.n = 32'(cur.size());
      exp_q.push_back(e);
      cur.delete();
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      if (!resetn) emitted = 0;
      @(negedge clk);
      if (resetn && out_en) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_out_en: got out_d=0x%08h with no word expected", out_d);
        end else begin
          e = exp_q.pop_front();
          chk("out_d", out_d, e.w);
          chk("out_count", 32'(out_count), e.n);
          chk("word_cnt_at_emit", 32'(word_cnt), 32'(emitted % (1 << CNT_W)));
          emitted++;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the byte is taken.
  task automatic send_byte(input logic [7:0] d, input logic last, output int waited,
                           output logic en_at_acc);
    in_valid  = 1'b1;
    in_data   = d;
    in_last   = last;
    waited    = 0;
    en_at_acc = 1'b0;
    @(negedge clk);
    while (!in_ready && waited < 60) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_total++;
      $display("FAIL accept_timeout: in_ready got 0 expected 1");
    end else begin
      en_at_acc = out_en;
      model_accept(d, last);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    in_last  = 1'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain_timeout: pending words got %0d expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input int m);
    mode = m;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    cur.delete();
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int   w;
    logic e;
    logic [31:0] bp_exp;
    resetn   = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_en", 32'(out_en), 32'd0);
    chk("reset_out_d", out_d, 32'd0);
    chk("reset_out_count", 32'(out_count), 32'd0);
    chk("reset_word_cnt", 32'(word_cnt), 32'd0);
    @(posedge clk);
    #1;

    // Full word
    send_byte(8'h11, 1'b0, w, e);
    send_byte(8'h22, 1'b0, w, e);
    send_byte(8'h33, 1'b0, w, e);
    send_byte(8'h44, 1'b0, w, e);
    drain();
    chk("full_word_cnt", 32'(word_cnt), 32'd1);

    // Partial word
    send_byte(8'hAA, 1'b0, w, e);
    send_byte(8'hBB, 1'b1, w, e);
    drain();

    // Backpressure hold
    set_mode(2);
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0, w, e);
`ifdef WORD_ASSEMBLER_BIG_ENDIAN_EN
    bp_exp = 32'h01020304;
`else
    bp_exp = 32'h04030201;
`endif
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_en", 32'(out_en), 32'd0);
      chk("bp_out_d", out_d, bp_exp);
      chk("bp_out_count", 32'(out_count), 32'd4);
    end
    @(posedge clk);
    #1;
    mode = 0;
    drain();

    // Overlap: back-to-back bytes across a word boundary
    for (int i = 0; i < 8; i++) begin
      send_byte(8'(8'h10 + i), 1'b0, w, e);
      chk("overlap_no_stall", 32'(w), 32'd0);
      if (i == 4) chk("overlap_0x14_with_out_en", 32'(e), 32'd1);
    end
    drain();

    // Reset mid-word
    send_byte(8'h55, 1'b0, w, e);
    send_byte(8'h66, 1'b0, w, e);
    do_reset();
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0, w, e);
    drain();
    chk("rst_mid_word_cnt", 32'(word_cnt), 32'd1);

    // Counter wrap at CNT_W=4
    do_reset();
    for (int k = 1; k <= 17; k++) begin
      for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b0, w, e);
      drain();
      chk("wrap_word_cnt", 32'(word_cnt), 32'(k % 16));
    end

    // Randomized traffic with random backpressure, gaps and early last
    set_mode(1);
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send_byte(8'($urandom), 1'($urandom_range(0, 4) == 0), w, e);
    end
    send_byte(8'($urandom), 1'b1, w, e);
    mode = 0;
    drain();
    chk("random_word_cnt", 32'(word_cnt), 32'(emitted % 16));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
